regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_scoreboard.sv | 38 +++
 rtl/regfile_mp.sv | 120 ++++++++++++
 tb/tb_regfile_mp.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the multi-port register file.
package regfile_pkg;

    typedef enum logic {
        RF_INIT = 1'b0,
        RF_RUN  = 1'b1
    } rf_state_e;

    localparam int RF_XLEN_DEF  = 32;
    localparam int RF_NREGS_DEF = 32;
    localparam int RF_NREAD_DEF = 2;

endpackage

// File: rtl/regfile_scoreboard.sv
// One busy bit per register: set by claim, cleared by a committed write, with NREAD lookups.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int NREGS = RF_NREGS_DEF,
    parameter  int NREAD = RF_NREAD_DEF,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  set_en,
    input  logic [AW-1:0]         set_addr,
    input  logic                  clr_en,
    input  logic [AW-1:0]         clr_addr,
    input  logic [NREAD*AW-1:0]   lk_addr,
    output logic [NREAD-1:0]      lk_busy
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Set is applied after clear so a same-cycle claim outlives the write.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) busy_d[clr_addr] = 1'b0;
        if (set_en) busy_d[set_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_lk
        assign lk_busy[i] = busy_q[lk_addr[i*AW +: AW]];
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with zeroing sweep after reset and a busy-bit scoreboard.
// Optional write-through to the read ports when REGFILE_BYPASS_EN is defined.
//
// state   | meaning
// RF_INIT | sweeping zeros into every register, one per cycle; ready = 0
// RF_RUN  | normal operation; ready = 1 until the next reset
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int XLEN     = RF_XLEN_DEF,
    parameter  int NREGS    = RF_NREGS_DEF,
    parameter  int NREAD    = RF_NREAD_DEF,
    parameter  int ZERO_REG = 1,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    output logic                    ready,
    input  logic [NREAD*AW-1:0]     rd_addr,
    output logic [NREAD*XLEN-1:0]   rd_data,
    output logic [NREAD-1:0]        rd_busy,
    input  logic                    we,
    input  logic [AW-1:0]           wr_addr,
    input  logic [XLEN-1:0]         wr_data,
    input  logic                    claim,
    input  logic [AW-1:0]           claim_addr
);

    rf_state_e         state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic              active;
    logic              wr_commit;
    logic              claim_ok;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [NREAD-1:0]  sb_busy;
    logic [XLEN-1:0]   mem [NREGS];

    assign ready     = (state_q == RF_RUN);
    assign active    = ready & en;
    assign wr_commit = active & we & ~((ZERO_REG != 0) && (wr_addr == '0));
    assign claim_ok  = active & claim & ~((ZERO_REG != 0) && (claim_addr == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RF_INIT;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // The sweep and normal writes share one storage port so it maps onto a RAM.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        mem_we    = 1'b0;
        mem_addr  = wr_addr;
        mem_wdata = wr_data;
        case (state_q)
            RF_INIT: begin
                mem_we    = 1'b1;
                mem_addr  = idx_q;
                mem_wdata = '0;
                idx_d     = idx_q + 1'b1;
                if (idx_q == AW'(NREGS - 1)) state_d = RF_RUN;
            end
            RF_RUN: begin
                mem_we = wr_commit;
            end
            default: state_d = RF_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NREAD (NREAD)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (claim_ok),
        .set_addr (claim_addr),
        .clr_en   (wr_commit),
        .clr_addr (wr_addr),
        .lk_addr  (rd_addr),
        .lk_busy  (sb_busy)
    );

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [AW-1:0]   addr;
        logic            zero_hit;
        logic [XLEN-1:0] stored;

        assign addr     = rd_addr[i*AW +: AW];
        assign zero_hit = (ZERO_REG != 0) && (addr == '0);
        assign stored   = mem[addr];

`ifdef REGFILE_BYPASS_EN
        logic byp;
        assign byp = wr_commit && (wr_addr == addr);

        // A forwarded write is about to clear the bit, unless a same-cycle claim re-sets it.
        assign rd_data[i*XLEN +: XLEN] = (!active || zero_hit) ? '0 :
                                         (byp ? wr_data : stored);
        assign rd_busy[i] = active && !zero_hit &&
                            (byp ? (claim_ok && (claim_addr == addr)) : sb_busy[i]);
`else
        assign rd_data[i*XLEN +: XLEN] = (!active || zero_hit) ? '0 : stored;
        assign rd_busy[i] = active && !zero_hit && sb_busy[i];
`endif
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: stimulus queues expected observations, a negedge monitor compares.
module tb_regfile_mp;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        ready;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        we;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        claim;
    logic [4:0]  claim_addr;

    typedef struct packed {
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  busy;
        logic        rdy;
    } obs_t;

    obs_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    passed = 0;

    regfile_mp dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .ready      (ready),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .we         (we),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .claim      (claim),
        .claim_addr (claim_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            obs_t  e;
            obs_t  g;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            g = {rd_data[31:0], rd_data[63:32], rd_busy, ready};
            checks++;
            if (g === e) passed++;
            else $display("FAIL %s: got d0=%h d1=%h busy=%b ready=%b, want d0=%h d1=%h busy=%b ready=%b",
                          n, g.d0, g.d1, g.busy, g.rdy, e.d0, e.d1, e.busy, e.rdy);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string n, input logic [31:0] d0, input logic [31:0] d1,
                       input logic [1:0] b, input logic r);
        exp_q.push_back({d0, d1, b, r});
        name_q.push_back(n);
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; we = 1'b0; claim = 1'b0;
        wr_addr = '0; wr_data = '0; claim_addr = '0;
        set_rd(5'd5, 5'd7);
        step();
        chk("reset_state", 32'h0, 32'h0, 2'b00, 1'b0);
        step();

        // Release and watch the 32-cycle sweep.
        rst_n = 1'b1;
        en    = 1'b1;
        for (int k = 0; k <= 34; k++) begin
            chk($sformatf("sweep_k%0d", k), 32'h0, 32'h0, 2'b00, k >= 32);
            step();
        end

        // Write x5, read it next cycle.
        we = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        set_rd(5'd5, 5'd0);
`ifdef REGFILE_BYPASS_EN
        chk("wr_x5_same_cycle", 32'hDEADBEEF, 32'h0, 2'b00, 1'b1);
`else
        chk("wr_x5_same_cycle", 32'h0, 32'h0, 2'b00, 1'b1);
`endif
        step();
        we = 1'b0;
        chk("rd_x5", 32'hDEADBEEF, 32'h0, 2'b00, 1'b1);
        step();

        // Write x0 is discarded.
        we = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
        set_rd(5'd0, 5'd0);
        chk("wr_x0_same_cycle", 32'h0, 32'h0, 2'b00, 1'b1);
        step();
        we = 1'b0;
        chk("rd_x0", 32'h0, 32'h0, 2'b00, 1'b1);
        step();

        // Claim x7, busy visible from the next cycle on port 1.
        claim = 1'b1; claim_addr = 5'd7;
        set_rd(5'd5, 5'd7);
        chk("claim_x7_same_cycle", 32'hDEADBEEF, 32'h0, 2'b00, 1'b1);
        step();
        claim = 1'b0;
        chk("busy_x7", 32'hDEADBEEF, 32'h0, 2'b10, 1'b1);
        step();

        // Write x7 clears busy.
        we = 1'b1; wr_addr = 5'd7; wr_data = 32'h55;
`ifdef REGFILE_BYPASS_EN
        chk("wr_x7_same_cycle", 32'hDEADBEEF, 32'h55, 2'b00, 1'b1);
`else
        chk("wr_x7_same_cycle", 32'hDEADBEEF, 32'h0, 2'b10, 1'b1);
`endif
        step();
        we = 1'b0;
        chk("x7_after_write", 32'hDEADBEEF, 32'h55, 2'b00, 1'b1);
        step();

        // Claim and write x9 together: claim wins, data still updates.
        we = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
        claim = 1'b1; claim_addr = 5'd9;
        set_rd(5'd9, 5'd7);
        step();
        we = 1'b0; claim = 1'b0;
        chk("claim_wr_x9", 32'h99, 32'h55, 2'b01, 1'b1);
        step();

        // Both ports on x3 during a write.
        we = 1'b1; wr_addr = 5'd3; wr_data = 32'hA5A5A5A5;
        set_rd(5'd3, 5'd3);
`ifdef REGFILE_BYPASS_EN
        chk("wr_x3_both_ports", 32'hA5A5A5A5, 32'hA5A5A5A5, 2'b00, 1'b1);
`else
        chk("wr_x3_both_ports", 32'h0, 32'h0, 2'b00, 1'b1);
`endif
        step();
        we = 1'b0;
        chk("rd_x3_both_ports", 32'hA5A5A5A5, 32'hA5A5A5A5, 2'b00, 1'b1);
        step();

        // Claim of x0 is discarded.
        claim = 1'b1; claim_addr = 5'd0;
        step();
        claim = 1'b0;
        set_rd(5'd0, 5'd9);
        chk("claim_x0_ignored", 32'h0, 32'h99, 2'b10, 1'b1);
        step();

        // en low: outputs forced to zero, write and claim ignored.
        en = 1'b0;
        set_rd(5'd9, 5'd9);
        chk("en_low_outputs", 32'h0, 32'h0, 2'b00, 1'b1);
        we = 1'b1; wr_addr = 5'd5; wr_data = 32'h1111;
        claim = 1'b1; claim_addr = 5'd5;
        step();
        we = 1'b0; claim = 1'b0; en = 1'b1;
        set_rd(5'd5, 5'd9);
        chk("en_low_ignored", 32'hDEADBEEF, 32'h99, 2'b10, 1'b1);
        step();

        // Reset during RUN with x9 claimed.
        rst_n = 1'b0;
        chk("reset_in_run", 32'h0, 32'h0, 2'b00, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) step();
        chk("sweep_idx10", 32'h0, 32'h0, 2'b00, 1'b0);

        // Reset again mid-sweep at idx 10.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int k = 1; k <= 33; k++) begin
            step();
            if (k >= 30)
                chk($sformatf("resweep_k%0d", k), 32'h0, 32'h0, 2'b00, k >= 32);
        end

        step();
        step();
        checks++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL queue_drain: got %0d pending, want 0", exp_q.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
